muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit; replaces the separate multiplier and divider
//  beside the multicycle CPU datapath. One start/busy/done handshake, one shared engine,
//  HI/LO results in MIPS layout, divide-by-zero flag for the control unit's exception path.
//  Adds a width parameter and signed/unsigned modes.
// PARAMETERS
//  WIDTH  32  operand width; product and remainder/quotient pair = 2*WIDTH bits (WIDTH >= 4, even)
// PORTS
//  clock      in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  start      in   1      request; sampled only when busy=0 and done=0
//  op         in   2      [0]: 0=mult 1=div; [1]: 1=unsigned (only if MULDIV_UNSIGNED_EN)
//  a_in       in   WIDTH  multiplicand / dividend
//  b_in       in   WIDTH  multiplier / divisor
//  busy       out  1      engine iterating; start ignored while high
//  done       out  1      one-cycle pulse: hi_out/lo_out (or div0_excp) valid
//  hi_out     out  WIDTH  mult: product[2W-1:W]; div: remainder
//  lo_out     out  WIDTH  mult: product[W-1:0];  div: quotient
//  div0_excp  out  1      one-cycle pulse with done when divisor==0
// BEHAVIOUR
//  - Reset: state IDLE; busy=0, done=0, div0_excp=0, hi_out=0, lo_out=0. Reset mid-op aborts, same values.
//  - States: IDLE -> (MUL|DIV) -> FIX -> DONE -> IDLE; IDLE -> DONE directly on div-by-zero.
//  - Start in cycle 0: operands latched as magnitudes (abs for signed) plus result-sign bits.
//    busy high cycles 1..WIDTH+1 (WIDTH iterations, then FIX); done high in cycle WIDTH+2.
//  - MUL: radix-2 shift-add, 1 bit/cycle, 2W-bit accumulator. DIV: restoring, 1 quotient bit/cycle.
//  - FIX: negate product if signs differ; quotient negated if signs differ; remainder takes
//    dividend sign (truncation toward zero). All arithmetic modulo 2^W per half.
//  - Signed MIN / -1: lo_out=MIN, hi_out=0, no exception.
//  - Div by zero (b_in==0 at start, div op): no iterations; done+div0_excp high in cycle 1;
//    hi_out/lo_out keep previous values; busy stays 0.
//  - hi_out/lo_out update only at DONE entry; held stable until next completed op.
//  - start asserted while busy or in DONE cycle: ignored (no queueing); op/a_in/b_in changes
//    during busy have no effect.
// CONFIGURATION
//  - MULDIV_UNSIGNED_EN defined: op[1]=1 selects multu/divu (no abs, no FIX negation).
//  - Not defined: op[1] ignored; all ops signed; unsigned datapath logic absent.
// STRUCTURE
//  - muldiv_pkg: op encodings (OP_MULT, OP_DIV, OP_UNSIGNED bit), state enum
//    (ST_IDLE, ST_MUL, ST_DIV, ST_FIX, ST_DONE), iteration counter width = $clog2(WIDTH+1).
//  - One sub-module: muldiv_sign_fix (combinational conditional negate, WIDTH-parametrised),
//    used for operand abs at start and result correction in FIX.
// TESTING (WIDTH=32)
//  - mult 7 * -3 at cycle 0 -> done cycle 34, hi=FFFFFFFF, lo=FFFFFFEB; busy high cycles 1..33.
//  - div -7 / 2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1); then div 100/7 -> lo=0000000E, hi=00000002.
//  - div 5 / 0 (prior hi/lo = 1/2) -> cycle 1: done=1, div0_excp=1; hi=1, lo=2 unchanged.
//  - div 80000000 / FFFFFFFF -> lo=80000000, hi=00000000, div0_excp=0.
//  - start pulse at cycle 10 of a busy mult ignored (result unchanged); reset at cycle 15 of
//    next op -> busy=0, done=0, hi=lo=0 next cycle; new op after reset completes normally.
//  - op=mult, op[1]=1, FFFFFFFF*FFFFFFFF: with MULDIV_UNSIGNED_EN hi=FFFFFFFE lo=00000001;
//    without it hi=00000000 lo=00000001.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and state type for the iterative multiply/divide unit.
// The unsigned-mode macro MULDIV_UNSIGNED_EN is consumed in muldiv_unit.
package muldiv_pkg;

  localparam logic OP_MULT         = 1'b0;
  localparam logic OP_DIV          = 1'b1;
  localparam int   OP_KIND_BIT     = 0;
  localparam int   OP_UNSIGNED_BIT = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  // Counter must hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate; used for operand magnitudes and result correction.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_in,
  input  logic         neg,
  output logic [W-1:0] val_out
);

  assign val_out = neg ? (W'(0) - val_in) : val_in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO results.
// Define MULDIV_UNSIGNED_EN to let op[1] select multu/divu.
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | waiting for start; outputs hold last result
// MUL     | one shift-add step per cycle, WIDTH steps
// DIV     | one restoring quotient bit per cycle, WIDTH steps
// FIX     | apply result signs, load hi/lo
// DONE    | done pulse (with div0_excp on divide by zero)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div0_excp
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_lo_q, neg_lo_d;
  logic                 neg_hi_q, neg_hi_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 div0_q, div0_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  logic                 is_unsigned;
  logic                 sign_a, sign_b;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_part, div_diff;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quot_fixed, rem_fixed;

`ifdef MULDIV_UNSIGNED_EN
  assign is_unsigned = op[OP_UNSIGNED_BIT];
`else
  logic unused_op_unsigned;
  assign unused_op_unsigned = op[OP_UNSIGNED_BIT];
  assign is_unsigned        = 1'b0;
`endif

  assign sign_a = a_in[WIDTH-1] & ~is_unsigned;
  assign sign_b = b_in[WIDTH-1] & ~is_unsigned;

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.val_in(a_in), .neg(sign_a), .val_out(a_abs));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.val_in(b_in), .neg(sign_b), .val_out(b_abs));

  // Multiply: low half shifts out multiplier bits while the product grows in from the top.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: high half is the partial remainder, low half turns dividend bits into quotient bits.
  assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_part - {1'b0, opb_q};
  assign div_next = div_diff[WIDTH]
                  ? {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                  : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (
    .val_in(acc_q), .neg(neg_lo_q), .val_out(prod_fixed)
  );
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quot (
    .val_in(acc_q[WIDTH-1:0]), .neg(neg_lo_q), .val_out(quot_fixed)
  );
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (
    .val_in(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_hi_q), .val_out(rem_fixed)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op[OP_KIND_BIT] == OP_DIV && b_in == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            div0_d  = 1'b1;
          end else begin
            state_d  = (op[OP_KIND_BIT] == OP_DIV) ? ST_DIV : ST_MUL;
            busy_d   = 1'b1;
            cnt_d    = CNT_W'(WIDTH);
            acc_d    = {{WIDTH{1'b0}}, a_abs};
            opb_d    = b_abs;
            is_div_d = (op[OP_KIND_BIT] == OP_DIV);
            neg_lo_d = sign_a ^ sign_b;
            neg_hi_d = sign_a;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = (state_q == ST_DIV) ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        hi_d    = is_div_q ? rem_fixed  : prod_fixed[2*WIDTH-1:WIDTH];
        lo_d    = is_div_q ? quot_fixed : prod_fixed[WIDTH-1:0];
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div0_excp = div0_q;
  assign hi_out    = hi_q;
  assign lo_out    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit (WIDTH=32) against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a_in, b_in;
  logic         busy, done, div0_excp;
  logic [W-1:0] hi_out, lo_out;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .hi_out(hi_out), .lo_out(lo_out), .div0_excp(div0_excp)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like the spec requires.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] h, output logic [W-1:0] l, output bit dz);
    bit uns;
    logic [63:0] p;
    longint sa, sb, q, r;
`ifdef MULDIV_UNSIGNED_EN
    uns = o[1];
`else
    uns = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    h = exp_hi;
    l = exp_lo;
    if (!o[0]) begin
      p = uns ? ({32'b0, a} * {32'b0, b}) : 64'(sa * sb);
      h = p[63:32];
      l = p[31:0];
    end else if (b == '0) begin
      dz = 1'b1;
    end else if (uns) begin
      l = a / b;
      h = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stray_cyc, input int abort_cyc, input bit start_in_done);
    logic [W-1:0] mh, ml;
    bit dz;
    int cyc, busy_cnt, first_busy, done_cyc;
    model(o, a, b, mh, ml, dz);
    @(negedge clock);
    op = o; a_in = a; b_in = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; op = 2'($urandom); a_in = $urandom; b_in = $urandom;
    cyc = 1; busy_cnt = 0; first_busy = -1; done_cyc = -1;
    while (cyc <= 60) begin
      if (busy) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == abort_cyc) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_hi", 64'(hi_out), 64'(0));
        chk("abort_lo", 64'(lo_out), 64'(0));
        exp_hi = '0;
        exp_lo = '0;
        return;
      end
      start = (cyc == stray_cyc);
      @(posedge clock); #1;
      start = 1'b0;
      cyc++;
    end
    if (done_cyc < 0) begin
      chk("done_timeout", 64'(1), 64'(0));
      return;
    end
    chk("done_cycle", 64'(done_cyc), dz ? 64'(1) : 64'(W + 2));
    chk("busy_cycles", 64'(busy_cnt), dz ? 64'(0) : 64'(W + 1));
    if (!dz) chk("busy_first", 64'(first_busy), 64'(1));
    chk("div0", 64'(div0_excp), 64'(dz));
    chk("hi", 64'(hi_out), 64'(mh));
    chk("lo", 64'(lo_out), 64'(ml));
    exp_hi = mh;
    exp_lo = ml;
    if (start_in_done) begin
      op = 2'b00; a_in = 32'd3; b_in = 32'd3; start = 1'b1;
    end
    @(posedge clock); #1;
    start = 1'b0;
    chk("done_pulse", 64'(done), 64'(0));
    chk("div0_pulse", 64'(div0_excp), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("hold_hi", 64'(hi_out), 64'(exp_hi));
    chk("hold_lo", 64'(lo_out), 64'(exp_lo));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [1:0] ro;
    reset = 1'b1; start = 1'b0; op = '0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_div0", 64'(div0_excp), 64'(0));
    chk("rst_hi", 64'(hi_out), 64'(0));
    chk("rst_lo", 64'(lo_out), 64'(0));
    reset = 1'b0;

    do_op(2'b00, 32'd7, 32'hFFFF_FFFD, -1, -1, 1'b0);
    chk("mult_7x-3_hi", 64'(hi_out), 64'hFFFF_FFFF);
    do_op(2'b01, 32'hFFFF_FFF9, 32'd2, -1, -1, 1'b1);
    chk("div_-7/2_lo", 64'(lo_out), 64'hFFFF_FFFD);
    do_op(2'b01, 32'd100, 32'd7, -1, -1, 1'b0);
    chk("div_100/7_lo", 64'(lo_out), 64'h0000_000E);
    do_op(2'b01, 32'd5, 32'd2, -1, -1, 1'b0);
    do_op(2'b01, 32'd5, 32'd0, -1, -1, 1'b0);
    chk("div0_hi_kept", 64'(hi_out), 64'd1);
    chk("div0_lo_kept", 64'(lo_out), 64'd2);
    do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, 1'b0);
    chk("min_div_lo", 64'(lo_out), 64'h8000_0000);
    do_op(2'b00, 32'd12345, 32'hFFFF_0001, 10, -1, 1'b0);
    do_op(2'b00, 32'd99, 32'd77, -1, 15, 1'b0);
    do_op(2'b01, 32'hFFFF_FF00, 32'd9, -1, -1, 1'b0);
    do_op(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, 1'b0);
`ifdef MULDIV_UNSIGNED_EN
    chk("multu_hi", 64'(hi_out), 64'hFFFF_FFFE);
`else
    chk("mult_ign_uns_hi", 64'(hi_out), 64'h0000_0000);
`endif
    chk("mult_ff_lo", 64'(lo_out), 64'h0000_0001);

    for (int i = 0; i < 60; i++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 33)) : -1,
            -1, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
